gamepad_port: RTL and testbench

- Peripheral-side responder for the CPU's gamepad port read. When the CPU selects the gamepad port and reads, this block drives the port bus with the current button state.
- Autonomously polls a serial (NES-style) controller: latch pulse, clocked shift-in of 8 active-low buttons.
- Holds the result in a stable register that is updated atomically once per frame.
- Sits on the ports bus alongside the other port devices; one instance per pad.

---
 rtl/gamepad_port.sv | 142 ++++++++++++++
 tb/tb_gamepad_port.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gamepad_port.sv
// Serial (NES-style) gamepad poller with a frame-atomic button register.
// Also answers CPU port reads by driving the port bus when selected.
module gamepad_port #(
  parameter logic [7:0]  PORT_ADDR     = 8'h01,
  parameter int unsigned CLK_DIV       = 4,
  parameter int unsigned POLL_INTERVAL = 1000
) (
  input  logic       clk,
  input  logic       mr,
  input  logic [7:0] portsel,
  input  logic       _port_rd,
  output logic [7:0] port_out,
  output logic       pad_latch,
  output logic       pad_clk,
  input  logic       pad_data,
  output logic       changed
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PW = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_INTERVAL - 1);

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    SETTLE,
    PULSE,
    COMMIT
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] poll_cnt_q, poll_cnt_d;
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    buttons_q, buttons_d;
  logic          changed_q, changed_d;
  logic          pad_latch_q, pad_latch_d;
  logic          pad_clk_q, pad_clk_d;
  logic [1:0]    sync_q, sync_d;
  logic          rd_sel;

  assign rd_sel    = (portsel == PORT_ADDR) && !_port_rd;
  assign port_out  = rd_sel ? buttons_q : 8'hzz;
  assign pad_latch = pad_latch_q;
  assign pad_clk   = pad_clk_q;
  assign changed   = changed_q;

  always_comb begin
    state_d     = state_q;
    poll_cnt_d  = poll_cnt_q;
    div_cnt_d   = div_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    buttons_d   = buttons_q;
    pad_latch_d = pad_latch_q;
    pad_clk_d   = pad_clk_q;
    sync_d      = {sync_q[0], pad_data};
    changed_d   = rd_sel ? 1'b0 : changed_q;
    unique case (state_q)
      IDLE: begin
        if (poll_cnt_q == POLL_LAST) begin
          poll_cnt_d  = '0;
          div_cnt_d   = '0;
          pad_latch_d = 1'b1;
          state_d     = LATCH;
        end else begin
          poll_cnt_d = poll_cnt_q + 1'b1;
        end
      end
      LATCH: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d   = '0;
          pad_latch_d = 1'b0;
          state_d     = SETTLE;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      SETTLE: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d          = '0;
          shift_d[bit_idx_q] = ~sync_q[1];
          if (bit_idx_q == 3'd7) begin
            state_d = COMMIT;
          end else begin
            pad_clk_d = 1'b1;
            state_d   = PULSE;
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      PULSE: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          pad_clk_d = 1'b0;
          bit_idx_d = bit_idx_q + 1'b1;
          state_d   = SETTLE;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      COMMIT: begin
        // A differing frame sets changed even if a read clears it this cycle
        buttons_d = shift_q;
        if (shift_q != buttons_q) changed_d = 1'b1;
        bit_idx_d = '0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge mr) begin
    if (mr) begin
      state_q     <= IDLE;
      poll_cnt_q  <= '0;
      div_cnt_q   <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      buttons_q   <= '0;
      changed_q   <= 1'b0;
      pad_latch_q <= 1'b0;
      pad_clk_q   <= 1'b0;
      sync_q      <= 2'b11;
    end else begin
      state_q     <= state_d;
      poll_cnt_q  <= poll_cnt_d;
      div_cnt_q   <= div_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      buttons_q   <= buttons_d;
      changed_q   <= changed_d;
      pad_latch_q <= pad_latch_d;
      pad_clk_q   <= pad_clk_d;
      sync_q      <= sync_d;
    end
  end

endmodule

// File: tb/tb_gamepad_port.sv
// Scoreboard bench for gamepad_port: two pads (CLK_DIV=2/POLL=16 and CLK_DIV=1/POLL=1)
// with a frame-schedule reference model and serial pad models.
module tb_gamepad_port;

  localparam logic [7:0] ADDR_A = 8'h21;
  localparam logic [7:0] ADDR_B = 8'h22;

  logic       clk = 1'b0;
  logic       mr = 1'b1;
  logic [7:0] portsel = 8'h00;
  logic       prd_n = 1'b1;
  logic       gl = 1'b0;
  logic       pd_a, pd_b;
  wire  [7:0] po_a, po_b;
  wire        pl_a, pc_a, ch_a, pl_b, pc_b, ch_b;

  int checks = 0;
  int errors = 0;

  gamepad_port #(
    .PORT_ADDR(ADDR_A), .CLK_DIV(2), .POLL_INTERVAL(16)
  ) u_a (
    .clk(clk), .mr(mr), .portsel(portsel), ._port_rd(prd_n),
    .port_out(po_a), .pad_latch(pl_a), .pad_clk(pc_a),
    .pad_data(pd_a), .changed(ch_a)
  );

  gamepad_port #(
    .PORT_ADDR(ADDR_B), .CLK_DIV(1), .POLL_INTERVAL(1)
  ) u_b (
    .clk(clk), .mr(mr), .portsel(portsel), ._port_rd(prd_n),
    .port_out(po_b), .pad_latch(pl_b), .pad_clk(pc_b),
    .pad_data(pd_b), .changed(ch_b)
  );

  always #5 clk = ~clk;

  // Scoreboard queues: expected committed value per frame, pushed at latch
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  // Pad A: latches a new button vector on latch, shifts on each pad_clk rise
  logic [7:0] dir_tbl[4] = '{8'hA5, 8'hA5, 8'h3C, 8'h5A};
  logic [7:0] fb_a = 8'h00;
  int         idx_a = 8;
  int         frame_a = 0;

  always @(posedge pl_a) begin : pad_a_load
    logic [7:0] v;
    if (frame_a < 4) v = dir_tbl[frame_a];
    else if ($urandom_range(0, 3) == 0) v = fb_a;
    else v = 8'($urandom);
    frame_a++;
    fb_a = v;
    idx_a = 0;
    q0.push_back(v);
  end

  always @(posedge pc_a) idx_a++;

  assign pd_a = ((idx_a < 8) ? ~fb_a[idx_a[2:0]] : 1'b1) ^ gl;

  // Pad B: all eight buttons held down
  always @(posedge pl_b) q1.push_back(8'hFF);
  assign pd_b = gl;

  // Sub-cycle glitches that never straddle a rising clock edge
  initial begin
    forever begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        #1 gl = 1'b1;
        #2 gl = 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model state per instance
  int         n[2];
  logic [7:0] mb[2];
  logic       mc[2];
  int         rises[2];
  bit         seen[2];
  logic       plat[2];
  logic       ppc[2];

  task automatic step(input int i, input logic lat, input logic pck,
                      input logic ch, input logic [7:0] pout);
    int cd, pol, f, p, o;
    logic rd, elat, eclk;
    logic [7:0] e, eport;
    string t;
    cd   = (i == 0) ? 2 : 1;
    pol  = (i == 0) ? 16 : 1;
    f    = 16 * cd + 1;
    p    = f + pol;
    t    = (i == 0) ? "a" : "b";
    rd   = (portsel == ((i == 0) ? ADDR_A : ADDR_B)) && !prd_n;
    elat = 1'b0;
    eclk = 1'b0;
    if (mr) begin
      n[i] = 0;
      mb[i] = 8'h00;
      mc[i] = 1'b0;
      rises[i] = 0;
      seen[i] = 1'b0;
      if (i == 0) q0.delete();
      else q1.delete();
    end else begin
      n[i]++;
      if (lat && !plat[i]) begin
        if (seen[i]) chk({t, "_clk_pulses"}, 8'(rises[i]), 8'd7);
        rises[i] = 0;
        seen[i] = 1'b1;
      end
      if (pck && !ppc[i]) rises[i]++;
      o = -1;
      if (n[i] >= pol) o = (n[i] - pol) % p;
      if (o >= 0 && o < cd) elat = 1'b1;
      else if (o >= cd && o < f - 1) eclk = (((o - cd) / cd) % 2) == 1;
      if (o == f) begin
        if (i == 0 && q0.size() > 0) e = q0.pop_front();
        else if (i == 1 && q1.size() > 0) e = q1.pop_front();
        else begin
          e = mb[i];
          checks++;
          errors++;
          $display("FAIL %s_scoreboard: commit with no frame queued", t);
        end
        if (e != mb[i]) mc[i] = 1'b1;
        else if (rd) mc[i] = 1'b0;
        mb[i] = e;
      end else if (rd) begin
        mc[i] = 1'b0;
      end
    end
    plat[i] = lat;
    ppc[i]  = pck;
    eport   = rd ? mb[i] : 8'hzz;
    chk({t, "_pad_latch"}, {7'd0, lat}, {7'd0, elat});
    chk({t, "_pad_clk"}, {7'd0, pck}, {7'd0, eclk});
    chk({t, "_changed"}, {7'd0, ch}, {7'd0, mc[i]});
    chk({t, "_port_out"}, pout, eport);
  endtask

  always @(posedge clk) begin
    #1;
    step(0, pl_a, pc_a, ch_a, po_a);
    step(1, pl_b, pc_b, ch_b, po_b);
  end

  task automatic wait_phase_a(input int o_tgt, input string nm);
    int k;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (n[0] >= 16 && ((n[0] - 16) % 49) == o_tgt) break;
    end
    if (k == 300) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout waiting for frame phase %0d", nm, o_tgt);
    end
  endtask

  task automatic random_traffic(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      case ($urandom_range(0, 4))
        0: portsel = ADDR_A;
        1: portsel = ADDR_B;
        2: portsel = 8'h00;
        3: portsel = 8'($urandom);
        default: ;
      endcase
      prd_n = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    int k;
    repeat (3) @(negedge clk);
    mr = 1'b0;

    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      case (c % 3)
        0: begin portsel = ADDR_A; prd_n = 1'b1; end
        1: begin portsel = 8'h00;  prd_n = 1'b0; end
        default: begin portsel = ADDR_B; prd_n = 1'b1; end
      endcase
    end

    // Continuous read across frames A5, A5, 3C
    @(negedge clk);
    portsel = ADDR_A;
    prd_n = 1'b0;
    for (k = 0; k < 400 && n[0] < 160; k++) @(negedge clk);
    prd_n = 1'b1;

    // Read only in the COMMIT cycle of the 3C -> 5A frame
    wait_phase_a(32, "commit_wait");
    portsel = ADDR_A;
    prd_n = 1'b0;
    #1 chk("commit_cycle_old_value", po_a, 8'h3C);
    @(negedge clk);
    prd_n = 1'b1;
    #1 chk("commit_set_wins", {7'd0, ch_a}, 8'd1);

    random_traffic(3000);

    // Reset during the pulse of bit 4
    wait_phase_a(20, "pulse4_wait");
    portsel = ADDR_A;
    prd_n = 1'b0;
    #1 chk("pulse4_clk_high", {7'd0, pc_a}, 8'd1);
    #1 mr = 1'b1;
    #1;
    chk("rst_pad_clk", {7'd0, pc_a}, 8'd0);
    chk("rst_pad_latch", {7'd0, pl_a}, 8'd0);
    chk("rst_changed", {7'd0, ch_a}, 8'd0);
    chk("rst_buttons", po_a, 8'h00);
    repeat (2) @(negedge clk);
    mr = 1'b0;
    for (k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (pl_a) break;
    end
    chk("latch_delay_after_rst", 8'(k), 8'd16);

    random_traffic(1500);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
